// File: rtl/pipelined_loop_ctrl.sv
// Control for one software-pipelined loop: issues an iteration every II cycles,
// tracks occupancy through DEPTH stages and pulses done once the pipe has drained.
module pipelined_loop_ctrl #(
  parameter int unsigned II    = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      trip_count,
  input  logic             stall,
  output logic             ready,
  output logic             busy,
  output logic             issue,
  output logic [31:0]      iter_idx,
  output logic [DEPTH-1:0] stage_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  localparam logic [31:0] II_LAST = 32'(II - 1);

  state_t           state;
  state_t           state_next;
  logic [31:0]      remaining;
  logic [31:0]      remaining_next;
  logic [31:0]      ii_cnt;
  logic [31:0]      ii_cnt_next;
  logic [31:0]      iter_idx_next;
  logic             issue_next;
  logic             done_next;
  logic [DEPTH-1:0] sv_shift;
  logic [DEPTH-1:0] sv_next;

  assign ready = (state == S_IDLE);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (!stall) begin
      state <= state_next;
    end
  end

  // The first issue is produced by the accept edge itself, so remaining counts
  // the issues still owed after the one currently on the output.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    ii_cnt_next    = ii_cnt;
    iter_idx_next  = iter_idx;
    issue_next     = 1'b0;
    done_next      = 1'b0;
    sv_shift       = stage_valid << 1;

    case (state)
      S_IDLE: begin
        if (start) begin
          iter_idx_next = '0;
          ii_cnt_next   = '0;
          if (trip_count == '0) begin
            done_next = 1'b1;
          end else begin
            issue_next     = 1'b1;
            remaining_next = trip_count - 32'd1;
            state_next     = (trip_count == 32'd1) ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (ii_cnt == II_LAST) begin
          issue_next     = 1'b1;
          ii_cnt_next    = '0;
          iter_idx_next  = iter_idx + 32'd1;
          remaining_next = remaining - 32'd1;
          if (remaining == 32'd1) begin
            state_next = S_DRAIN;
          end
        end else begin
          ii_cnt_next = ii_cnt + 32'd1;
        end
      end
      S_DRAIN: begin
        if (sv_shift == '0) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    sv_next = sv_shift | DEPTH'(issue_next);
  end

  // A stalled edge holds every counter and the stage pipe; only the
  // single-cycle pulses are cleared so they reappear once the stall lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= '0;
      ii_cnt      <= '0;
      iter_idx    <= '0;
      issue       <= 1'b0;
      done        <= 1'b0;
      stage_valid <= '0;
    end else if (stall) begin
      issue <= 1'b0;
      done  <= 1'b0;
    end else begin
      remaining   <= remaining_next;
      ii_cnt      <= ii_cnt_next;
      iter_idx    <= iter_idx_next;
      issue       <= issue_next;
      done        <= done_next;
      stage_valid <= sv_next;
    end
  end

endmodule

// File: tb/tb_pipelined_loop_ctrl.sv
// Directed bench for pipelined_loop_ctrl: per-cycle expected waveforms given as
// bit masks indexed by cycle number, with cycle 0 being the accept cycle.
module tb_pipelined_loop_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_stall, a_ready, a_busy, a_issue, a_done;
  logic [31:0] a_trip, a_idx;
  logic [2:0]  a_sv;
  logic        b_start, b_stall, b_ready, b_busy, b_issue, b_done;
  logic [31:0] b_trip, b_idx;
  logic [1:0]  b_sv;

  pipelined_loop_ctrl #(.II(2), .DEPTH(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .trip_count(a_trip), .stall(a_stall),
    .ready(a_ready), .busy(a_busy), .issue(a_issue), .iter_idx(a_idx),
    .stage_valid(a_sv), .done(a_done)
  );

  pipelined_loop_ctrl #(.II(1), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .trip_count(b_trip), .stall(b_stall),
    .ready(b_ready), .busy(b_busy), .issue(b_issue), .iter_idx(b_idx),
    .stage_valid(b_sv), .done(b_done)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [2:0]  sv_tab [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    a_start = 1'b0; a_stall = 1'b0; a_trip = '0;
    b_start = 1'b0; b_stall = 1'b0; b_trip = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset a ready", {31'b0, a_ready}, 32'd1);
    check_eq("reset a busy",  {31'b0, a_busy},  32'd0);
    check_eq("reset a idx",   a_idx,            32'd0);
    check_eq("reset a sv",    {29'b0, a_sv},    32'd0);
    check_eq("reset b done",  {31'b0, b_done},  32'd0);
    check_eq("reset b idx",   b_idx,            32'd0);
  endtask

  task automatic run_case(input string name, input bit use_b, input logic [31:0] trip,
                          input logic [15:0] start_m, input logic [15:0] stall_m,
                          input logic [15:0] rst_m, input logic [15:0] issue_m,
                          input logic [15:0] done_m, input logic [15:0] busy_m,
                          input int ncyc);
    int unsigned cnt;
    logic        o_ready, o_busy, o_issue, o_done;
    logic [31:0] o_idx, o_sv;
    cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      o_ready = use_b ? b_ready : a_ready;
      o_busy  = use_b ? b_busy  : a_busy;
      o_issue = use_b ? b_issue : a_issue;
      o_done  = use_b ? b_done  : a_done;
      o_idx   = use_b ? b_idx   : a_idx;
      o_sv    = use_b ? {30'b0, b_sv} : {29'b0, a_sv};

      if (c > 0 && (rst_m[c-1] || (start_m[c-1] && !busy_m[c-1] && !stall_m[c-1])))
        cnt = 0;
      check_eq($sformatf("%s c%0d issue", name, c), {31'b0, o_issue}, {31'b0, issue_m[c]});
      check_eq($sformatf("%s c%0d done",  name, c), {31'b0, o_done},  {31'b0, done_m[c]});
      check_eq($sformatf("%s c%0d busy",  name, c), {31'b0, o_busy},  {31'b0, busy_m[c]});
      check_eq($sformatf("%s c%0d ready", name, c), {31'b0, o_ready}, {31'b0, !busy_m[c]});
      check_eq($sformatf("%s c%0d sv",    name, c), o_sv, {29'b0, sv_tab[c]});
      if (issue_m[c]) begin
        check_eq($sformatf("%s c%0d idx", name, c), o_idx, 32'(cnt));
        cnt++;
      end else if (c > 0 && rst_m[c-1]) begin
        check_eq($sformatf("%s c%0d idx after rst", name, c), o_idx, 32'd0);
      end

      rst = rst_m[c];
      if (use_b) begin
        b_start = start_m[c]; b_stall = stall_m[c]; b_trip = trip;
      end else begin
        a_start = start_m[c]; a_stall = stall_m[c]; a_trip = trip;
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    a_start = 1'b0; a_stall = 1'b0;
    b_start = 1'b0; b_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_stall = 1'b0; a_trip = '0;
    b_start = 1'b0; b_stall = 1'b0; b_trip = '0;

    // II=2, DEPTH=3, N=4
    do_reset();
    sv_tab = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5,
               3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_case("n4", 1'b0, 32'd4, 16'h0001, 16'h0000, 16'h0000,
             16'h00AA, 16'h0400, 16'h03FE, 13);

    // single iteration goes straight to drain
    do_reset();
    sv_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0,
               3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_case("n1", 1'b0, 32'd1, 16'h0001, 16'h0000, 16'h0000,
             16'h0002, 16'h0010, 16'h000E, 7);

    // zero trip count: done next cycle, never busy
    do_reset();
    sv_tab = '{default: 3'd0};
    run_case("n0", 1'b0, 32'd0, 16'h0001, 16'h0000, 16'h0000,
             16'h0000, 16'h0002, 16'h0000, 5);

    // stall during cycles 4..6 pushes issues and done out by three
    do_reset();
    sv_tab = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd2, 3'd2, 3'd2, 3'd2,
               3'd5, 3'd2, 3'd5, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
    run_case("stall", 1'b0, 32'd4, 16'h0001, 16'h0070, 16'h0000,
             16'h050A, 16'h2000, 16'h1FFE, 15);

    // start while busy ignored; start on the done cycle relaunches
    do_reset();
    sv_tab = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5,
               3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd5, 3'd0, 3'd0};
    run_case("restart", 1'b0, 32'd4, 16'h0405, 16'h0000, 16'h0000,
             16'h28AA, 16'h0400, 16'h3BFE, 14);

    // reset mid-loop at cycle 4, fresh start at cycle 7
    do_reset();
    sv_tab = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd2, 3'd0, 3'd0, 3'd0,
               3'd1, 3'd2, 3'd5, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0};
    run_case("midrst", 1'b0, 32'd4, 16'h0081, 16'h0000, 16'h0010,
             16'h150A, 16'h0000, 16'h1F1E, 13);

    // maximum trip count: only the opening issues are observed
    do_reset();
    sv_tab = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5,
               3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_case("nmax", 1'b0, 32'hFFFF_FFFF, 16'h0001, 16'h0000, 16'h0000,
             16'h00AA, 16'h0000, 16'h00FE, 8);

    // II=1, DEPTH=2, N=3 on the second instance
    do_reset();
    sv_tab = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0,
               3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_case("ii1", 1'b1, 32'd3, 16'h0001, 16'h0000, 16'h0000,
             16'h000E, 16'h0020, 16'h001E, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
